otter_rf_wb_arbiter: RTL and testbench

- Shares the single write port of the OTTER register file between NREQ writeback sources: ALU pipe, load unit and multicycle mul/div.
- Arbitration is round-robin.
- A 32-entry busy scoreboard tracks destination registers with an outstanding write, so issue logic can stall on RAW/WAW hazards.
- Sits between the writeback sources and the register file write port (RegWrite/WriteReg/WriteData). The register file commits on the falling clock edge.

---
 rtl/otter_rf_wb_arbiter.sv | 73 +++++++
 tb/tb_otter_rf_wb_arbiter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/otter_rf_wb_arbiter.sv
// otter_rf_wb_arbiter: round-robin share of the register file write port plus a busy scoreboard for hazards
module otter_rf_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           chk_rs1,
  input  logic [4:0]           chk_rs2,
  input  logic [4:0]           chk_rd,
  output logic                 hazard,
  output logic [31:0]          busy
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr_q, ptr_d, g, idx;
  logic          found, hs;
  logic [4:0]    sel_rd, rf_waddr_q, rf_waddr_d;
  logic [31:0]   sel_data, rf_wdata_q, rf_wdata_d, busy_q, busy_d;
  logic          rf_we_q, rf_we_d;
  always_comb begin
    found = 1'b0;
    g = '0;
    idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        g = idx;
      end
    end
    hs = found & ~reset;
    req_ready = '0;
    sel_rd = '0;
    sel_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (hs && PW'(k) == g) begin
        req_ready[k] = 1'b1;
        sel_rd = req_rd[5*k +: 5];
        sel_data = req_data[32*k +: 32];
      end
    end
    ptr_d = reset ? '0 : hs ? (g == PW'(NREQ - 1) ? '0 : g + 1'b1) : ptr_q;
    // writes to x0 complete the handshake but never reach the register file
    rf_we_d = hs && sel_rd != 5'd0;
    rf_waddr_d = reset ? 5'd0 : rf_we_d ? sel_rd : rf_waddr_q;
    rf_wdata_d = reset ? 32'd0 : rf_we_d ? sel_data : rf_wdata_q;
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (reset) busy_d = '0;
  end
  always_ff @(posedge clock) begin
    ptr_q <= ptr_d;
    rf_we_q <= rf_we_d;
    rf_waddr_q <= rf_waddr_d;
    rf_wdata_q <= rf_wdata_d;
    busy_q <= busy_d;
  end
  assign rf_we = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy = busy_q;
  assign hazard = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
endmodule

// File: tb/tb_otter_rf_wb_arbiter.sv
// tb_otter_rf_wb_arbiter: cycle-by-cycle vector table plus directed reset and wait sequences
module tb_otter_rf_wb_arbiter;
  logic        clock, reset;
  logic [2:0]  req_valid, req_ready;
  logic [14:0] req_rd;
  logic [95:0] req_data;
  logic        rf_we, iss_valid, hazard;
  logic [4:0]  rf_waddr, iss_rd, chk_rs1, chk_rs2, chk_rd;
  logic [31:0] rf_wdata, busy;
  int total = 0, bad = 0, row = 0;

  otter_rf_wb_arbiter #(.NREQ(3)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .chk_rd(chk_rd), .hazard(hazard), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic rst; logic [2:0] v; logic [14:0] rds; logic [95:0] ds;
    logic iv; logic [4:0] ird, rs1, rs2, crd;
    logic [2:0] erdy; logic ewe; logic [4:0] ewa; logic [31:0] ewd; logic ehaz; logic [31:0] ebusy;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic rst, input logic [2:0] v, input logic [4:0] rd2, rd1, rd0,
                     input logic [31:0] d2, d1, d0, input logic iv, input logic [4:0] ird, rs1, rs2, crd,
                     input logic [2:0] erdy, input logic ewe, input logic [4:0] ewa,
                     input logic [31:0] ewd, input logic ehaz, input logic [31:0] ebusy);
    vq.push_back('{rst: rst, v: v, rds: {rd2, rd1, rd0}, ds: {d2, d1, d0}, iv: iv, ird: ird,
                   rs1: rs1, rs2: rs2, crd: crd, erdy: erdy, ewe: ewe, ewa: ewa, ewd: ewd,
                   ehaz: ehaz, ebusy: ebusy});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    // reset/grant cases
    add(1, 3'b111, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    add(0, 3'b010, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 5, 32'hDEADBEEF, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 5, 32'hDEADBEEF, 0, 0);
    add(0, 3'b101, 4, 0, 3, 32'hC0000004, 0, 32'hA0000003, 0, 0, 0, 0, 0, 3'b100, 0, 5, 32'hDEADBEEF, 0, 0);
    add(0, 3'b001, 0, 0, 3, 0, 0, 32'hA0000003, 0, 0, 0, 0, 0, 3'b001, 1, 4, 32'hC0000004, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 3, 32'hA0000003, 0, 0);
    add(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 3, 32'hA0000003, 0, 0);
    // round-robin with all requesters valid
    add(0, 3'b111, 3, 2, 1, 32'h33333333, 32'h22222222, 32'h11111111, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0);
    add(0, 3'b111, 3, 2, 1, 32'h33333333, 32'h22222222, 32'h11111111, 0, 0, 0, 0, 0, 3'b010, 1, 1, 32'h11111111, 0, 0);
    add(0, 3'b111, 3, 2, 1, 32'h33333333, 32'h22222222, 32'h11111111, 0, 0, 0, 0, 0, 3'b100, 1, 2, 32'h22222222, 0, 0);
    add(0, 3'b111, 3, 2, 1, 32'h33333333, 32'h22222222, 32'h11111111, 0, 0, 0, 0, 0, 3'b001, 1, 3, 32'h33333333, 0, 0);
    add(0, 3'b111, 3, 2, 1, 32'h33333333, 32'h22222222, 32'h11111111, 0, 0, 0, 0, 0, 3'b010, 1, 1, 32'h11111111, 0, 0);
    add(0, 3'b111, 3, 2, 1, 32'h33333333, 32'h22222222, 32'h11111111, 0, 0, 0, 0, 0, 3'b100, 1, 2, 32'h22222222, 0, 0);
    // x0 drop, then scoreboard set/clear/hazard
    add(0, 3'b001, 0, 0, 0, 0, 0, 32'h12345678, 0, 0, 0, 0, 0, 3'b001, 1, 3, 32'h33333333, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 0, 3'b000, 0, 3, 32'h33333333, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 3'b000, 0, 3, 32'h33333333, 1, 32'h80);
    add(0, 3'b100, 7, 0, 0, 32'h77777777, 0, 0, 0, 0, 0, 7, 0, 3'b100, 0, 3, 32'h33333333, 1, 32'h80);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 3'b000, 1, 7, 32'h77777777, 1, 32'h80);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, 3'b000, 0, 7, 32'h77777777, 0, 0);
    add(0, 3'b010, 0, 7, 0, 0, 32'h7A7A7A7A, 0, 0, 0, 7, 0, 0, 3'b010, 0, 7, 32'h77777777, 1, 32'h80);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 7, 3'b000, 1, 7, 32'h7A7A7A7A, 1, 32'h80);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7, 3'b000, 0, 7, 32'h7A7A7A7A, 1, 32'h80);
    add(0, 3'b001, 0, 0, 7, 0, 0, 32'h70707070, 1, 12, 0, 0, 0, 3'b001, 0, 7, 32'h7A7A7A7A, 0, 32'h80);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 12, 0, 0, 3'b000, 1, 7, 32'h70707070, 1, 32'h1080);
    // mid-operation reset with a write in flight and busy bits set
    add(0, 3'b001, 0, 0, 12, 0, 0, 32'hCCCC0012, 0, 0, 0, 0, 0, 3'b001, 0, 7, 32'h70707070, 0, 32'h1200);
    add(1, 3'b010, 0, 9, 0, 0, 32'h99999999, 0, 0, 0, 9, 0, 0, 3'b000, 1, 12, 32'hCCCC0012, 1, 32'h1200);
    add(0, 3'b111, 14, 9, 13, 32'hE000000E, 32'h99999999, 32'hD000000D, 0, 0, 9, 0, 0, 3'b001, 0, 0, 0, 0, 0);
    add(0, 3'b110, 14, 9, 0, 32'hE000000E, 32'h99999999, 0, 0, 0, 9, 0, 0, 3'b010, 1, 13, 32'hD000000D, 0, 0);
    add(0, 3'b100, 14, 0, 0, 32'hE000000E, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 9, 32'h99999999, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 14, 32'hE000000E, 0, 0);
    add(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 14, 32'hE000000E, 0, 0);

    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      row = i;
      reset = vq[i].rst; req_valid = vq[i].v; req_rd = vq[i].rds; req_data = vq[i].ds;
      iss_valid = vq[i].iv; iss_rd = vq[i].ird;
      chk_rs1 = vq[i].rs1; chk_rs2 = vq[i].rs2; chk_rd = vq[i].crd;
      #1;
      chk("req_ready", req_ready, vq[i].erdy);
      chk("rf_we", rf_we, vq[i].ewe);
      chk("rf_waddr", rf_waddr, vq[i].ewa);
      chk("rf_wdata", rf_wdata, vq[i].ewd);
      chk("hazard", hazard, vq[i].ehaz);
      chk("busy", busy, vq[i].ebusy);
      @(posedge clock);
      #1;
    end

    // reset held two cycles with every requester valid: no grants
    row = 100;
    iss_valid = 1'b0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    reset = 1'b1; req_valid = 3'b111; req_rd = {5'd3, 5'd2, 5'd1};
    req_data = {32'h33333333, 32'h22222222, 32'h11111111};
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_ready", req_ready, 3'b000);
      @(posedge clock);
      #1;
      chk("rst_we", rf_we, 1'b0);
      chk("rst_busy", busy, 32'd0);
    end
    reset = 1'b0;
    #1;
    chk("rel_ready", req_ready, 3'b001);
    // requester 2 waits behind 0 and 1 before its grant
    n = 0;
    while (!req_ready[2] && n < 8) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("wait_req2_cycles", n, 2);
    @(posedge clock);
    #1;
    req_valid = '0;
    chk("req2_we", rf_we, 1'b1);
    chk("req2_waddr", rf_waddr, 5'd3);
    chk("req2_wdata", rf_wdata, 32'h33333333);
    @(posedge clock);
    #1;
    chk("idle_we", rf_we, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
